// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
//   master (pipeline): drives start_i, op_i, word_i, a_i, b_i, flush_i;
//                      observes ready_o, valid_o, lo_o, hi_o, dbz_o.
//   slave  (unit)    : the mirror image.
// Signal names keep the unit's _i/_o view so both sides read the same.
interface muldiv_if #(
  parameter int WIDTH = 64
);
  logic             start_i;
  logic [1:0]       op_i;
  logic             word_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] lo_o;
  logic [WIDTH-1:0] hi_o;
  logic             dbz_o;

  modport master (
    output start_i, op_i, word_i, a_i, b_i, flush_i,
    input  ready_o, valid_o, lo_o, hi_o, dbz_o
  );

  modport slave (
    input  start_i, op_i, word_i, a_i, b_i, flush_i,
    output ready_o, valid_o, lo_o, hi_o, dbz_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MUL/MULU/DIV/DIVU for the MIPS64 execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus (slave) - start_i/op_i/word_i/a_i/b_i/flush_i in,
//                 ready_o/valid_o/lo_o/hi_o/dbz_o out
// op_i: 00 MUL, 01 MULU, 10 DIV, 11 DIVU. word_i selects 32-bit ops (WIDTH=64 only).
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish as soon as the
// remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | ready for a request
// PREP  | extend operands, take magnitudes, record result signs
// RUN   | one multiply or divide step per cycle, counter down to zero
// FIX   | sign-correct and present the result with valid_o
module muldiv_unit #(
  parameter int WIDTH = 64
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d, is_sgn_q, is_sgn_d, word_q, word_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sgn_q, sgn_d, sgn_r_q, sgn_r_d, dz_q, dz_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               dbz_q, dbz_d;

  function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
    logic signed [31:0] s;
    s = x;
    return WIDTH'(s);
  endfunction

  // Operand extension and magnitudes, consumed in PREP.
  logic [WIDTH-1:0] ext_a, ext_b, mag_a, mag_b;
  logic             sa, sb;
  always_comb begin
    ext_a = a_q;
    ext_b = b_q;
    if (word_q) begin
      if (is_sgn_q) begin
        ext_a = sext32(a_q[31:0]);
        ext_b = sext32(b_q[31:0]);
      end else begin
        ext_a = WIDTH'(a_q[31:0]);
        ext_b = WIDTH'(b_q[31:0]);
      end
    end
    sa    = is_sgn_q & ext_a[WIDTH-1];
    sb    = is_sgn_q & ext_b[WIDTH-1];
    mag_a = sa ? -ext_a : ext_a;
    mag_b = sb ? -ext_b : ext_b;
  end

  // Divide step: acc = {remainder, dividend/quotient}. In word mode the
  // dividend sits in the low 32 bits, so its next bit enters from bit 31.
  logic [WIDTH:0]   trial;
  logic             bit_in, ge;
  logic [WIDTH-1:0] rem_nx;
  always_comb begin
    bit_in = word_q ? acc_q[31] : acc_q[WIDTH-1];
    trial  = {acc_q[2*WIDTH-1:WIDTH], bit_in};
    ge     = trial >= {1'b0, b_q};
    rem_nx = ge ? WIDTH'(trial - {1'b0, b_q}) : trial[WIDTH-1:0];
  end

  // Sign correction and output formatting.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, quo_s, rem_s, fix_lo, fix_hi;
  always_comb begin
    prod  = sgn_q ? -acc_q : acc_q;
    quo   = word_q ? WIDTH'(acc_q[31:0]) : acc_q[WIDTH-1:0];
    quo_s = sgn_q ? -quo : quo;
    rem_s = sgn_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (dz_q) begin
      fix_lo = '1;
      fix_hi = a_q;
    end else if (is_div_q) begin
      fix_lo = word_q ? sext32(quo_s[31:0]) : quo_s;
      fix_hi = word_q ? sext32(rem_s[31:0]) : rem_s;
    end else if (word_q) begin
      fix_lo = sext32(prod[31:0]);
      fix_hi = sext32(prod[63:32]);
    end else begin
      fix_lo = prod[WIDTH-1:0];
      fix_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    word_d   = word_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    sgn_r_d  = sgn_r_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          is_div_d = bus.op_i[1];
          is_sgn_d = ~bus.op_i[0];
          word_d   = (WIDTH == 64) && bus.word_i;
          a_d      = bus.a_i;
          b_d      = bus.b_i;
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        a_d     = ext_a;  // kept for the divide-by-zero remainder
        b_d     = mag_b;
        sgn_d   = sa ^ sb;
        sgn_r_d = sa;
        cnt_d   = word_q ? CW'(32) : CW'(WIDTH);
        dz_d    = is_div_q && (mag_b == '0);
        if (is_div_q) begin
          acc_d = {{WIDTH{1'b0}}, mag_a};
        end else begin
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, mag_a};
        end
        state_d = (is_div_q && (mag_b == '0)) ? S_FIX : S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q && (mag_b == '0)) state_d = S_FIX;
`endif
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_d = {rem_nx, acc_q[WIDTH-2:0], ge};
        end else begin
          // Multiplicand shifts left instead of the accumulator shifting
          // right, so stopping early needs no final realignment.
          if (b_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end
        if (cnt_q == CW'(1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q && (b_q[WIDTH-1:1] == '0)) state_d = S_FIX;
`endif
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush_i) begin
          lo_d  = fix_lo;
          hi_d  = fix_hi;
          dbz_d = dz_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      word_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      sgn_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      word_q   <= word_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      sgn_r_q  <= sgn_r_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dbz_q    <= dbz_d;
    end
  end

  // The result is visible during FIX itself; a flush there hides it and
  // leaves the previous result in place.
  logic fix_fire;
  assign fix_fire    = (state_q == S_FIX) && !bus.flush_i;
  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.valid_o = fix_fire;
  assign bus.lo_o    = fix_fire ? fix_lo : lo_q;
  assign bus.hi_o    = fix_fire ? fix_hi : hi_q;
  assign bus.dbz_o   = fix_fire ? dz_q : dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  always @(negedge clk) if (bus.valid_o === 1'b1) vcount++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference model straight from the arithmetic rules.
  function automatic void model(input logic [1:0] op, input logic word,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] lo, output logic [63:0] hi,
                                output logic dbz, output int lat);
    logic sgn;
    logic [63:0] ea, eb, p64;
    logic [127:0] p128;
    longint sx, sy, sq, sr;
    int wx, wy, wq, wr;
    int unsigned ux, uy;
    longint unsigned uq, ur;
`ifdef MULDIV_EARLY_OUT_EN
    logic [63:0] mb;
`endif
    sgn = ~op[0];
    ea  = word ? (sgn ? sx32(a[31:0]) : {32'b0, a[31:0]}) : a;
    eb  = word ? (sgn ? sx32(b[31:0]) : {32'b0, b[31:0]}) : b;
    dbz = 1'b0;
    lat = word ? 34 : 66;
    if (!op[1]) begin
      if (word) begin
        p64 = ea * eb;
        lo  = sx32(p64[31:0]);
        hi  = sx32(p64[63:32]);
      end else begin
        p128 = (sgn ? {{64{ea[63]}}, ea} : {64'b0, ea}) *
               (sgn ? {{64{eb[63]}}, eb} : {64'b0, eb});
        lo = p128[63:0];
        hi = p128[127:64];
      end
`ifdef MULDIV_EARLY_OUT_EN
      mb  = (sgn && eb[63]) ? -eb : eb;
      lat = 2;
      for (int i = 0; i < 64; i++) if (mb[i]) lat = i + 3;
`endif
    end else if (eb == 64'd0) begin
      lo = '1; hi = ea; dbz = 1'b1; lat = 2;
    end else if (sgn && word) begin
      wx = ea[31:0]; wy = eb[31:0];
      if (wx == 32'h8000_0000 && wy == -1) begin wq = wx; wr = 0; end
      else begin wq = wx / wy; wr = wx % wy; end
      lo = sx32(wq); hi = sx32(wr);
    end else if (sgn) begin
      sx = ea; sy = eb;
      if (sx == 64'h8000_0000_0000_0000 && sy == -1) begin sq = sx; sr = 0; end
      else begin sq = sx / sy; sr = sx % sy; end
      lo = sq; hi = sr;
    end else if (word) begin
      ux = ea[31:0]; uy = eb[31:0];
      lo = sx32(ux / uy); hi = sx32(ux % uy);
    end else begin
      uq = ea / eb; ur = ea % eb;
      lo = uq; hi = ur;
    end
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return '1;
      3: return 64'd1;
      4: return {32'h0, $urandom()};
      5: return 64'($urandom_range(0, 255));
      6: return {32'hFFFF_FFFF, 32'h8000_0000};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Issue one request and capture the first valid_o (lat=-1 on timeout).
  task automatic do_op(input logic [1:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] lo, output logic [63:0] hi,
                       output logic dbz, output int lat);
    int c;
    c = 0;
    while (bus.ready_o !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.word_i = word; bus.a_i = a; bus.b_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = -1; lo = 'x; hi = 'x; dbz = 1'bx;
    for (c = 1; c <= 200; c++) begin
      if (bus.valid_o === 1'b1) begin
        lat = c; lo = bus.lo_o; hi = bus.hi_o; dbz = bus.dbz_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = 2'b00; bus.word_i = 1'b0;
    bus.a_i = '0; bus.b_i = '0;
    #12;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.lo_o !== 64'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo_o); end
    checks++; if (bus.hi_o !== 64'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi_o); end
    checks++; if (bus.dbz_o !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus.dbz_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] op; logic word; logic [63:0] a, b, lo, hi; logic dbz; int lat;
  } vec_t;

  task automatic test_directed;
    vec_t vt[5];
    logic [63:0] lo, hi; logic dbz; int lat;
`ifdef MULDIV_EARLY_OUT_EN
    vt[0] = '{2'b00, 1'b0, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, '1, 1'b0, 5};
    vt[1] = '{2'b01, 1'b1, 64'h8000_0000, 64'd2, 64'd0, 64'd1, 1'b0, 4};
`else
    vt[0] = '{2'b00, 1'b0, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, '1, 1'b0, 66};
    vt[1] = '{2'b01, 1'b1, 64'h8000_0000, 64'd2, 64'd0, 64'd1, 1'b0, 34};
`endif
    vt[2] = '{2'b10, 1'b0, -64'sd7, 64'd2, -64'sd3, '1, 1'b0, 66};
    vt[3] = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 66};
    vt[4] = '{2'b11, 1'b0, 64'd42, 64'd0, '1, 64'd42, 1'b1, 2};
    for (int i = 0; i < 5; i++) begin
      do_op(vt[i].op, vt[i].word, vt[i].a, vt[i].b, lo, hi, dbz, lat);
      checks++; if (lat !== vt[i].lat) begin errors++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, vt[i].lat); end
      checks++; if (lo !== vt[i].lo) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, vt[i].lo); end
      checks++; if (hi !== vt[i].hi) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, vt[i].hi); end
      checks++; if (dbz !== vt[i].dbz) begin errors++; $display("FAIL dir%0d_dbz: got %b want %b", i, dbz, vt[i].dbz); end
    end
  endtask

  task automatic test_random;
    logic [1:0] op; logic word; logic [63:0] a, b, lo, hi, elo, ehi; logic dbz, edbz; int lat, elat;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3)); word = 1'($urandom_range(0, 1));
      a = pick(); b = pick();
      model(op, word, a, b, elo, ehi, edbz, elat);
      do_op(op, word, a, b, lo, hi, dbz, lat);
      checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_lat op=%0d w=%b a=%h b=%h: got %0d want %0d", i, op, word, a, b, lat, elat); end
      checks++; if (lo !== elo) begin errors++; $display("FAIL rnd%0d_lo op=%0d w=%b a=%h b=%h: got %h want %h", i, op, word, a, b, lo, elo); end
      checks++; if (hi !== ehi) begin errors++; $display("FAIL rnd%0d_hi op=%0d w=%b a=%h b=%h: got %h want %h", i, op, word, a, b, hi, ehi); end
      checks++; if (dbz !== edbz) begin errors++; $display("FAIL rnd%0d_dbz: got %b want %b", i, dbz, edbz); end
    end
  endtask

  task automatic test_flush;
    logic [63:0] lo, hi; logic dbz; int lat, v0, c;
    do_op(2'b11, 1'b0, 64'd100, 64'd7, lo, hi, dbz, lat);
    checks++; if (lo !== 64'd14 || hi !== 64'd2) begin errors++; $display("FAIL flush_pre: got %h/%h want 14/2", lo, hi); end
    // flush in RUN at cycle 10
    @(negedge clk); @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b10; bus.word_i = 1'b0; bus.a_i = -64'sd1000; bus.b_i = 64'd3;
    @(negedge clk);
    bus.start_i = 1'b0; v0 = vcount;
    for (c = 1; c < 10; c++) @(negedge clk);
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.ready_o); end
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready11: got %b want 1", bus.ready_o); end
    checks++; if (bus.lo_o !== 64'd14 || bus.hi_o !== 64'd2) begin errors++; $display("FAIL flush_hold: got %h/%h want 14/2", bus.lo_o, bus.hi_o); end
    repeat (80) @(negedge clk);
    checks++; if (vcount !== v0) begin errors++; $display("FAIL flush_novalid: got %0d want %0d", vcount, v0); end
    do_op(2'b10, 1'b0, -64'sd1000, 64'd3, lo, hi, dbz, lat);
    checks++; if (lo !== 64'hFFFF_FFFF_FFFF_FEB3 || hi !== '1 || lat !== 66) begin errors++; $display("FAIL flush_restart: got %h/%h lat %0d want fffffffffffffeb3/ffffffffffffffff lat 66", lo, hi, lat); end
    // flush during FIX of a divide-by-zero
    @(negedge clk); @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b11; bus.a_i = 64'd42; bus.b_i = 64'd0;
    @(negedge clk);
    bus.start_i = 1'b0; v0 = vcount;
    @(posedge clk); #2 bus.flush_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL flushfix_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.lo_o !== 64'hFFFF_FFFF_FFFF_FEB3 || bus.dbz_o !== 1'b0) begin errors++; $display("FAIL flushfix_hold: got %h dbz %b want fffffffffffffeb3 dbz 0", bus.lo_o, bus.dbz_o); end
    @(posedge clk); #2 bus.flush_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready_o !== 1'b1 || vcount !== v0) begin errors++; $display("FAIL flushfix_idle: got ready %b valids %0d want 1 %0d", bus.ready_o, vcount - v0, 0); end
    // start together with flush in IDLE is accepted
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 2'b11; bus.a_i = 64'd50; bus.b_i = 64'd0;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1 || bus.hi_o !== 64'd50 || bus.dbz_o !== 1'b1) begin errors++; $display("FAIL flush_start_idle: got valid %b hi %h dbz %b want 1 32 1", bus.valid_o, bus.hi_o, bus.dbz_o); end
  endtask

  task automatic test_reset_mid;
    int v0;
    repeat (2) @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b00; bus.word_i = 1'b0; bus.a_i = 64'd12345; bus.b_i = -64'sd9;
    @(negedge clk);
    bus.start_i = 1'b0; v0 = vcount;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.lo_o !== 64'd0 || bus.hi_o !== 64'd0) begin errors++; $display("FAIL rstmid_lohi: got %h/%h want 0/0", bus.lo_o, bus.hi_o); end
    checks++; if (bus.dbz_o !== 1'b0 || bus.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got dbz %b valid %b want 0 0", bus.dbz_o, bus.valid_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    checks++; if (vcount !== v0) begin errors++; $display("FAIL rstmid_novalid: got %0d want %0d", vcount, v0); end
  endtask

  task automatic test_busy;
    logic [63:0] elo, ehi, lo, hi; logic edbz; int elat, lat, c, v0;
    model(2'b01, 1'b0, 64'd123456789, 64'd987654321, elo, ehi, edbz, elat);
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.word_i = 1'b0;
    bus.a_i = 64'd123456789; bus.b_i = 64'd987654321;
    @(negedge clk);
    bus.start_i = 1'b0; v0 = vcount;
    c = 1; lat = -1; lo = 'x; hi = 'x;
    while (c <= 200) begin
      if (bus.valid_o === 1'b1) begin lat = c; lo = bus.lo_o; hi = bus.hi_o; break; end
      bus.start_i = (c == 3 || c == 15);
      bus.op_i = 2'b11; bus.a_i = 64'd99; bus.b_i = 64'd0;
      @(negedge clk); c++;
    end
    bus.start_i = 1'b0;
    checks++; if (lat !== elat) begin errors++; $display("FAIL busy_lat: got %0d want %0d", lat, elat); end
    checks++; if (lo !== elo || hi !== ehi) begin errors++; $display("FAIL busy_result: got %h/%h want %h/%h", lo, hi, elo, ehi); end
    repeat (80) @(negedge clk);
    checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL busy_onevalid: got %0d want 1", vcount - v0); end
  endtask

  task automatic test_early_out;
    logic [63:0] lo, hi; logic dbz; int lat;
    do_op(2'b00, 1'b0, 64'd5, 64'd1, lo, hi, dbz, lat);
`ifdef MULDIV_EARLY_OUT_EN
    checks++; if (lat !== 3) begin errors++; $display("FAIL eo_5x1_lat: got %0d want 3", lat); end
`else
    checks++; if (lat !== 66) begin errors++; $display("FAIL eo_5x1_lat: got %0d want 66", lat); end
`endif
    checks++; if (lo !== 64'd5 || hi !== 64'd0) begin errors++; $display("FAIL eo_5x1_val: got %h/%h want 5/0", lo, hi); end
    do_op(2'b00, 1'b0, 64'd7, 64'd0, lo, hi, dbz, lat);
`ifdef MULDIV_EARLY_OUT_EN
    checks++; if (lat !== 2) begin errors++; $display("FAIL eo_x0_lat: got %0d want 2", lat); end
`else
    checks++; if (lat !== 66) begin errors++; $display("FAIL eo_x0_lat: got %0d want 66", lat); end
`endif
    checks++; if (lo !== 64'd0 || hi !== 64'd0 || dbz !== 1'b0) begin errors++; $display("FAIL eo_x0_val: got %h/%h dbz %b want 0/0 0", lo, hi, dbz); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_busy();
    test_early_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
